// File: rtl/adc_pkg.sv
// Shared definitions for the ADC hold path.
//
// Contents:
//   hold_gen_state_t  - hold_tick_gen FSM state encoding
//   ADC_HOLD_CYCLES   - default minimum dwell in HOLDING
//   ADC_HOLD_TIMEOUT  - default HOLDING watchdog limit
//   cnt_width()       - bits needed to hold a given maximum count value
package adc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitPeriod,
    StWaitAck,
    StHolding,
    StRelease,
    StWaitDrop
  } hold_gen_state_t;

  localparam int unsigned ADC_HOLD_CYCLES  = 64;
  localparam int unsigned ADC_HOLD_TIMEOUT = 1023;

  // Minimum width (at least 1) able to represent max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((max_val >> w) != 0)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/reload_down_counter.sv
// Loadable down-counter with terminal-count flag. Saturates at zero.
//
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset (count cleared)
//   load_i      load load_val_i (has priority over dec_i)
//   load_val_i  value to load
//   dec_i       decrement by one when non-zero
//   tc_o        high while the count is zero
module reload_down_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             tc_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/hold_tick_gen.sv
// ADC hold handshake timing source.
//
// Issues periodic one-cycle hold_tick pulses until the hold counter answers with
// hold_enable, keeps the hold for at least HOLD_CYCLES and until conv_done has been
// seen, then issues one release_tick and waits for hold_enable to drop.
//
// Optional feature macro: HOLD_TIMEOUT_EN - adds a HOLDING watchdog that forces a
// release after TIMEOUT cycles and sets the sticky timeout_err flag.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         run enable (level)
//   period        hold_tick spacing in cycles (0 behaves as 1)
//   hold_enable   acknowledge from the hold counter
//   conv_done     one-cycle conversion-complete pulse
//   clr_err       clears timeout_err (ignored without HOLD_TIMEOUT_EN)
//   hold_tick     one-cycle pulse
//   release_tick  one-cycle pulse
//   busy          high in every state except idle
//   tick_count    number of hold_ticks issued, wrapping
//   timeout_err   sticky watchdog flag (constant 0 without HOLD_TIMEOUT_EN)
module hold_tick_gen
  import adc_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned HOLD_CYCLES = ADC_HOLD_CYCLES,
  parameter int unsigned TIMEOUT     = ADC_HOLD_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] period,
  input  logic             hold_enable,
  input  logic             conv_done,
  input  logic             clr_err,
  output logic             hold_tick,
  output logic             release_tick,
  output logic             busy,
  output logic [7:0]       tick_count,
  output logic             timeout_err
);

  localparam int unsigned DwellW = cnt_width(HOLD_CYCLES - 1);
  localparam logic [DwellW-1:0] DwellLoad = DwellW'(HOLD_CYCLES - 1);

  hold_gen_state_t state_q;
  logic            hold_tick_q, release_tick_q, busy_q, done_q;
  logic [7:0]      tick_count_q;

  logic             in_run, period_tc, period_load, period_dec;
  logic [DIV_W-1:0] period_load_val;
  logic             dwell_tc, dwell_load, dwell_dec;
  logic             hold_exit, wd_fire;

  // Counter control, decoded from the current state and inputs.
  always_comb begin
    in_run          = start && ((state_q == StWaitPeriod) || (state_q == StWaitAck));
    period_load_val = (period == '0) ? '0 : period - DIV_W'(1);
    period_load     = ((state_q == StIdle) && start) ||
                      (in_run && period_tc) ||
                      ((state_q == StWaitDrop) && !hold_enable && start);
    period_dec      = in_run && !period_tc;
    dwell_load      = start && (state_q == StWaitAck) && hold_enable;
    dwell_dec       = (state_q == StHolding);
    // A conv_done arriving in the same cycle as dwell expiry still counts.
    hold_exit       = (state_q == StHolding) && dwell_tc && (done_q || conv_done);
  end

  reload_down_counter #(
    .Width (DIV_W)
  ) u_period_cnt (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (period_load),
    .load_val_i (period_load_val),
    .dec_i      (period_dec),
    .tc_o       (period_tc)
  );

  reload_down_counter #(
    .Width (DwellW)
  ) u_dwell_cnt (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (dwell_load),
    .load_val_i (DwellLoad),
    .dec_i      (dwell_dec),
    .tc_o       (dwell_tc)
  );

`ifdef HOLD_TIMEOUT_EN
  localparam int unsigned WdW = cnt_width(TIMEOUT - 1);
  localparam logic [WdW-1:0] WdLoad = WdW'(TIMEOUT - 1);

  logic wd_tc, timeout_err_q;

  reload_down_counter #(
    .Width (WdW)
  ) u_wd_cnt (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (dwell_load),
    .load_val_i (WdLoad),
    .dec_i      (dwell_dec),
    .tc_o       (wd_tc)
  );

  assign wd_fire = (state_q == StHolding) && wd_tc && !hold_exit;

  // Set beats clear when both happen together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err_q <= 1'b0;
    end else if (wd_fire) begin
      timeout_err_q <= 1'b1;
    end else if (clr_err) begin
      timeout_err_q <= 1'b0;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_cfg;
  assign unused_cfg  = ^{clr_err, TIMEOUT};
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      hold_tick_q    <= 1'b0;
      release_tick_q <= 1'b0;
      busy_q         <= 1'b0;
      tick_count_q   <= '0;
      done_q         <= 1'b0;
    end else begin
      hold_tick_q    <= 1'b0;
      release_tick_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StWaitPeriod;
            busy_q  <= 1'b1;
          end
        end
        StWaitPeriod: begin
          if (!start) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (period_tc) begin
            hold_tick_q  <= 1'b1;
            tick_count_q <= tick_count_q + 8'd1;
            state_q      <= StWaitAck;
          end
        end
        StWaitAck: begin
          if (!start) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            if (period_tc) begin
              hold_tick_q  <= 1'b1;
              tick_count_q <= tick_count_q + 8'd1;
            end
            if (hold_enable) begin
              // Drop any conv_done seen before the hold began.
              done_q  <= 1'b0;
              state_q <= StHolding;
            end
          end
        end
        StHolding: begin
          if (conv_done) begin
            done_q <= 1'b1;
          end
          if (hold_exit || wd_fire) begin
            state_q <= StRelease;
          end
        end
        StRelease: begin
          release_tick_q <= 1'b1;
          state_q        <= StWaitDrop;
        end
        StWaitDrop: begin
          if (!hold_enable) begin
            if (start) begin
              state_q <= StWaitPeriod;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign hold_tick    = hold_tick_q;
  assign release_tick = release_tick_q;
  assign busy         = busy_q;
  assign tick_count   = tick_count_q;

endmodule

// File: tb/tb_hold_tick_gen.sv
module tb_hold_tick_gen;

  localparam int unsigned DivW  = 16;
  localparam int unsigned HoldC = 8;
  localparam int unsigned ToutC = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [DivW-1:0] period;
  logic            hold_enable;
  logic            conv_done;
  logic            clr_err;
  logic            hold_tick;
  logic            release_tick;
  logic            busy;
  logic [7:0]      tick_count;
  logic            timeout_err;

  int n_vec  = 0;
  int n_miss = 0;
  int n_ticks_seen = 0;
  int n_rel_seen   = 0;
  int c;

  typedef struct {
    logic       start;
    logic [15:0] period;
    logic       hold_enable;
    logic       conv_done;
    logic       clr_err;
    logic       exp_tick;
    logic       exp_rel;
    logic       exp_busy;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl[19];

  hold_tick_gen #(
    .DIV_W       (DivW),
    .HOLD_CYCLES (HoldC),
    .TIMEOUT     (ToutC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .period       (period),
    .hold_enable  (hold_enable),
    .conv_done    (conv_done),
    .clr_err      (clr_err),
    .hold_tick    (hold_tick),
    .release_tick (release_tick),
    .busy         (busy),
    .tick_count   (tick_count),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input int p, input logic he, input logic cd,
                              input logic ce, input logic et, input logic er,
                              input logic eb, input int ec);
    vec_t v;
    v.start = s;  v.period = 16'(p); v.hold_enable = he; v.conv_done = cd; v.clr_err = ce;
    v.exp_tick = et; v.exp_rel = er; v.exp_busy = eb; v.exp_cnt = 8'(ec);
    return v;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    if (hold_tick) n_ticks_seen++;
    if (release_tick) n_rel_seen++;
    check("tick_overlap", int'(hold_tick & release_tick), 0);
  endtask

  // Steps until the selected pulse appears; cycles = steps taken, -1 if none within limit.
  task automatic wait_pulse(input bit rel, input int limit, output int cycles);
    bit found;
    found  = 1'b0;
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      if (!found) begin
        step();
        if (rel ? release_tick : hold_tick) begin
          found  = 1'b1;
          cycles = i;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; period = '0; hold_enable = 1'b0; conv_done = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_ticks_seen = 0;
    n_rel_seen   = 0;
  endtask

  initial begin
    // period=2, ack coinciding with the 2nd tick, conv_done pulses at entry (ignored)
    // and 2 cycles into the hold; HOLD_CYCLES=8 so release lands 9 edges after entry.
    tbl[0]  = mk(1, 2, 0, 0, 0, 0, 0, 1, 0);
    tbl[1]  = mk(1, 2, 0, 0, 0, 0, 0, 1, 0);
    tbl[2]  = mk(1, 2, 0, 0, 0, 1, 0, 1, 1);
    tbl[3]  = mk(1, 2, 0, 0, 0, 0, 0, 1, 1);
    tbl[4]  = mk(1, 2, 1, 1, 0, 1, 0, 1, 2);
    tbl[5]  = mk(1, 2, 1, 0, 0, 0, 0, 1, 2);
    tbl[6]  = mk(1, 2, 1, 1, 0, 0, 0, 1, 2);
    for (int i = 7; i <= 12; i++) tbl[i] = mk(1, 2, 1, 0, 0, 0, 0, 1, 2);
    tbl[13] = mk(1, 2, 1, 0, 0, 0, 1, 1, 2);
    tbl[14] = mk(1, 2, 0, 0, 0, 0, 0, 1, 2);
    tbl[15] = mk(1, 2, 0, 0, 0, 0, 0, 1, 2);
    tbl[16] = mk(1, 2, 0, 0, 0, 1, 0, 1, 3);
    tbl[17] = mk(0, 2, 0, 0, 0, 0, 0, 0, 3);
    tbl[18] = mk(0, 2, 0, 0, 0, 0, 0, 0, 3);

    // Reset state
    do_reset();
    check("rst_hold_tick", int'(hold_tick), 0);
    check("rst_release_tick", int'(release_tick), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tick_count", int'(tick_count), 0);
    check("rst_timeout_err", int'(timeout_err), 0);

    // Table-driven cycle-by-cycle sequence
    for (int i = 0; i < 19; i++) begin
      start = tbl[i].start; period = tbl[i].period; hold_enable = tbl[i].hold_enable;
      conv_done = tbl[i].conv_done; clr_err = tbl[i].clr_err;
      step();
      check($sformatf("vec%0d_hold_tick", i), int'(hold_tick), int'(tbl[i].exp_tick));
      check($sformatf("vec%0d_release_tick", i), int'(release_tick), int'(tbl[i].exp_rel));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].exp_busy));
      check($sformatf("vec%0d_tick_count", i), int'(tick_count), int'(tbl[i].exp_cnt));
    end
    conv_done = 1'b0;

    // Periodic ticks without ack: period=5, ticks 5/10/15/20 edges after the start edge
    do_reset();
    period = 16'd5; start = 1'b1;
    step();
    for (int k = 1; k <= 22; k++) begin
      step();
      check($sformatf("periodic_k%0d", k), int'(hold_tick), int'((k % 5) == 0));
    end
    check("periodic_tick_count", int'(tick_count), 4);

    // Full handshake: period=4, ack after 4th tick, conv_done 3 cycles into hold
    do_reset();
    period = 16'd4; start = 1'b1;
    wait_pulse(1'b0, 10, c);
    check("hs_first_tick", c - 1, 4);
    for (int t = 2; t <= 4; t++) begin
      wait_pulse(1'b0, 10, c);
      check($sformatf("hs_spacing%0d", t), c, 4);
    end
    hold_enable = 1'b1;
    step();
    step();
    step();
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    wait_pulse(1'b1, 20, c);
    check("hs_release_latency", (c < 0) ? -1 : c + 3, 9);
    hold_enable = 1'b0;
    wait_pulse(1'b0, 10, c);
    check("hs_resume", c - 1, 4);

    // Late conv_done; an earlier conv_done in WAIT_ACK must not shorten the hold
    do_reset();
    period = 16'd3; start = 1'b1;
    wait_pulse(1'b0, 10, c);
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    hold_enable = 1'b1;
    step();
    n_rel_seen = 0;
    repeat (19) step();
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    check("late_no_early_release", n_rel_seen, 0);
    wait_pulse(1'b1, 5, c);
    check("late_release_at_21", c, 1);

    // start drop in WAIT_ACK
    do_reset();
    period = 16'd2; start = 1'b1;
    wait_pulse(1'b0, 10, c);
    start = 1'b0;
    step();
    check("drop_ack_busy", int'(busy), 0);
    n_ticks_seen = 0;
    repeat (6) step();
    check("drop_ack_no_ticks", n_ticks_seen, 0);

    // start drop in HOLDING: release still issued, idle after hold_enable falls
    do_reset();
    period = 16'd2; start = 1'b1;
    wait_pulse(1'b0, 10, c);
    hold_enable = 1'b1;
    step();
    start = 1'b0;
    step();
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    wait_pulse(1'b1, 20, c);
    check("drop_hold_release", c, 7);
    repeat (2) step();
    check("drop_hold_busy_wait", int'(busy), 1);
    hold_enable = 1'b0;
    step();
    check("drop_hold_idle", int'(busy), 0);

    // Asynchronous reset in the middle of HOLDING
    do_reset();
    period = 16'd2; start = 1'b1;
    wait_pulse(1'b0, 10, c);
    hold_enable = 1'b1;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_tick_count", int'(tick_count), 0);
    check("arst_pulses", int'(hold_tick | release_tick), 0);
    start = 1'b0; hold_enable = 1'b0;
    step();
    rst_n = 1'b1;
    n_ticks_seen = 0; n_rel_seen = 0;
    repeat (5) step();
    check("arst_quiet", n_ticks_seen + n_rel_seen, 0);
    period = 16'd3; start = 1'b1;
    wait_pulse(1'b0, 10, c);
    check("arst_restart", c - 1, 3);

    // period=0 behaves as 1: a tick every cycle
    do_reset();
    period = 16'd0; start = 1'b1;
    step();
    repeat (5) step();
    check("period0_ticks", n_ticks_seen, 5);
    check("period0_tick_count", int'(tick_count), 5);

    // Watchdog
    do_reset();
    period = 16'd1; start = 1'b1;
    wait_pulse(1'b0, 10, c);
    hold_enable = 1'b1;
    step();
`ifdef HOLD_TIMEOUT_EN
    wait_pulse(1'b1, 40, c);
    check("wd_forced_release", c, int'(ToutC) + 1);
    check("wd_err_set", int'(timeout_err), 1);
    hold_enable = 1'b0; start = 1'b0;
    repeat (2) step();
    check("wd_err_sticky", int'(timeout_err), 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("wd_err_cleared", int'(timeout_err), 0);
`else
    n_rel_seen = 0;
    for (int k = 0; k < 40; k++) begin
      clr_err = k[0];
      step();
    end
    clr_err = 1'b0;
    check("nowd_no_release", n_rel_seen, 0);
    check("nowd_err_zero", int'(timeout_err), 0);
    check("nowd_still_busy", int'(busy), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hold_tick_gen.md
# hold_tick_gen

Timing source that drives the ADC hold handshake. It issues periodic single-cycle `hold_tick` pulses until the downstream hold counter acknowledges with `hold_enable`. It then keeps the hold for a minimum dwell and until the ADC reports `conv_done`, and finally issues `release_tick`. It sits between the run-control logic and the hold counter on the DE10-Standard ADC path, and produces the tick/release stimulus that the hold counter consumes.

## Interface
Parameters:
- `DIV_W`, 16, width of the period counter and `period` input
- `HOLD_CYCLES`, 64, minimum cycles in HOLDING before release is allowed (≥1)
- `TIMEOUT`, 1023, HOLDING watchdog limit in cycles (only with `HOLD_TIMEOUT_EN`)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  level; run enable
- `period`  in  DIV_W  hold_tick spacing in cycles; 0 treated as 1; sampled at every counter reload
- `hold_enable`  in  1  acknowledge from hold counter
- `conv_done`  in  1  one-cycle pulse from ADC conversion logic
- `clr_err`  in  1  clears `timeout_err`
- `hold_tick`  out  1  one-cycle pulse
- `release_tick`  out  1  one-cycle pulse
- `busy`  out  1  high in every state except IDLE
- `tick_count`  out  8  hold_ticks issued, wraps 255→0
- `timeout_err`  out  1  sticky watchdog flag (tied 0 without macro)

## Operation
- Reset: state IDLE. All outputs 0. Counters 0. Done-latch clear.
- IDLE: if `start`=1, load period counter with `max(period,1)-1` and go to WAIT_PERIOD.
- WAIT_PERIOD: decrement the counter. At 0, pulse `hold_tick`, increment `tick_count`, reload the counter, and go to WAIT_ACK.
- WAIT_ACK: the period counter keeps running and re-pulses `hold_tick` at each expiry. This repeats because the hold counter needs several ticks before it acknowledges.
  - `hold_enable`=1: load the dwell counter with `HOLD_CYCLES-1`, clear the done-latch, and go to HOLDING.
  - If `hold_enable` rises in the same cycle as a period expiry, the tick is still issued and the state goes to HOLDING.
- HOLDING:
  - Decrement the dwell counter to 0 and saturate there.
  - Latch `conv_done`. A `conv_done` pulse seen before HOLDING is ignored.
  - When dwell=0 and the latch is set (including a `conv_done` in that same cycle), go to RELEASE.
- RELEASE: pulse `release_tick` for one cycle, then go to WAIT_DROP.
- WAIT_DROP: wait for `hold_enable`=0.
  - Then with `start`=1: reload the period counter and go to WAIT_PERIOD.
  - Otherwise go to IDLE.
- `start` dropping:
  - In WAIT_PERIOD or WAIT_ACK: go to IDLE next cycle. No further pulses.
  - In HOLDING, RELEASE or WAIT_DROP: the sequence completes. A hold is never abandoned while asserted.
- `hold_tick` and `release_tick` are never high in the same cycle.

## Timing
- First `hold_tick`: high exactly `max(period,1)` cycles after the first clock edge that sees `start`=1.
- Tick spacing in WAIT_ACK: `max(period,1)` cycles between pulse rising edges.
- HOLDING entry: the cycle after `hold_enable` is sampled high.
- `release_tick`: high 1 cycle after the HOLDING exit condition is met.
- Minimum HOLDING-entry to `release_tick`: `HOLD_CYCLES`+1 cycles.
- All outputs are registered. No combinational input-to-output paths.

## Configuration
- `HOLD_TIMEOUT_EN` defined:
  - A watchdog counts cycles in HOLDING.
  - If the count reaches `TIMEOUT` without the exit condition, go to RELEASE (forced `release_tick`) and set `timeout_err`.
  - `timeout_err` stays set until `clr_err`=1 or reset. If set and clear occur in the same cycle, set wins.
- `HOLD_TIMEOUT_EN` undefined:
  - No watchdog. HOLDING waits indefinitely for `conv_done`.
  - `timeout_err` is constant 0 and `clr_err` is ignored.

## Structure
- Shared package `adc_pkg` holds:
  - the state enum `hold_gen_state_t` (IDLE, WAIT_PERIOD, WAIT_ACK, HOLDING, RELEASE, WAIT_DROP);
  - default constants `ADC_HOLD_CYCLES` and `ADC_HOLD_TIMEOUT`.
- One sub-module: `reload_down_counter`, a loadable down-counter with a terminal-count flag. It is instantiated for the period counter and the dwell counter, and for the watchdog when enabled.

## Test plan
- Reset mid-HOLDING (assert `rst_n`=0): all outputs 0 and `busy`=0 immediately (asynchronous). After release, no pulse until `start` is seen.
- Periodic ticks without ack: `period`=5, `start`=1, `hold_enable`=0 → `hold_tick` at cycles 5, 10, 15, 20; `tick_count`=4.
- Full handshake:
  - Setup: `period`=4, `HOLD_CYCLES`=8, `hold_enable` rises after the 4th tick, `conv_done` 3 cycles later.
  - Required: `release_tick` 9 cycles after HOLDING entry.
  - Required: after `hold_enable` drops, ticks resume 4 cycles later.
- Late `conv_done`: `conv_done` 20 cycles into HOLDING with `HOLD_CYCLES`=8 → `release_tick` on cycle 21. A `conv_done` pulse during WAIT_ACK does not shorten the hold.
- `start` drop: drop `start` in WAIT_ACK → no further ticks, IDLE next cycle. Drop `start` in HOLDING → `release_tick` still issued, then IDLE after `hold_enable`=0.
- `HOLD_TIMEOUT_EN` with `TIMEOUT`=32, no `conv_done` → forced `release_tick` and `timeout_err`=1. `clr_err` pulse clears `timeout_err`. `period`=0 behaves as 1.
